fp_cmp_scheduler: RTL and testbench

Shares one registered floating-point greater-or-equal compare unit among NUM_REQ requesters. Requesters are served round-robin, one operation in flight at a time.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_ge_unit.sv | 69 ++++++
 rtl/fp_cmp_scheduler.sv | 133 +++++++++++++
 tb/tb_fp_cmp_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and IEEE-754 field helpers for the floating-point compare scheduler.
// Helpers take field widths as arguments so any precision up to 64 bits can use them.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  function automatic logic fp_sign(input fp_word_t x, input int precision);
    return ((x >> (precision - 1)) & fp_word_t'(1)) != fp_word_t'(0);
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t x, input int exp_size, input int mantissa_size);
    return (x >> mantissa_size) & ((fp_word_t'(1) << exp_size) - fp_word_t'(1));
  endfunction

  function automatic fp_word_t fp_mant(input fp_word_t x, input int mantissa_size);
    return x & ((fp_word_t'(1) << mantissa_size) - fp_word_t'(1));
  endfunction

  // Quiet and signalling NaNs are treated alike.
  function automatic logic is_nan(input fp_word_t x, input int exp_size, input int mantissa_size);
    return (fp_exp(x, exp_size, mantissa_size) == ((fp_word_t'(1) << exp_size) - fp_word_t'(1))) &&
           (fp_mant(x, mantissa_size) != fp_word_t'(0));
  endfunction

  function automatic logic is_zero(input fp_word_t x, input int exp_size, input int mantissa_size);
    return (fp_exp(x, exp_size, mantissa_size) == fp_word_t'(0)) &&
           (fp_mant(x, mantissa_size) == fp_word_t'(0));
  endfunction

endpackage

// File: rtl/fp_ge_unit.sv
// Registered IEEE-754 greater-or-equal compare; done pulses one cycle after start.
// Infinities and denormals are ordered by the plain magnitude compare.
module fp_ge_unit
  import fp_pkg::*;
#(
  parameter int precision     = 32,
  parameter int exp_size      = 8,
  parameter int mantissa_size = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [precision-1:0] a,
  input  logic [precision-1:0] b,
  output logic                 done,
  output logic                 ge,
  output logic                 nan
);

  localparam fp_word_t MAG_MASK = (fp_word_t'(1) << (precision - 1)) - fp_word_t'(1);

  fp_word_t a_w_s;
  fp_word_t b_w_s;
  fp_word_t mag_a_s;
  fp_word_t mag_b_s;
  logic     sign_a_s;
  logic     sign_b_s;
  logic     ge_s;
  logic     nan_s;

  // Combinational compare of the latched operand pair.
  always_comb begin
    a_w_s    = fp_word_t'(a);
    b_w_s    = fp_word_t'(b);
    mag_a_s  = a_w_s & MAG_MASK;
    mag_b_s  = b_w_s & MAG_MASK;
    sign_a_s = fp_sign(a_w_s, precision);
    sign_b_s = fp_sign(b_w_s, precision);
    nan_s    = is_nan(a_w_s, exp_size, mantissa_size) || is_nan(b_w_s, exp_size, mantissa_size);
    ge_s     = 1'b0;
    if (nan_s) begin
      ge_s = 1'b0;
    end else if (is_zero(a_w_s, exp_size, mantissa_size) && is_zero(b_w_s, exp_size, mantissa_size)) begin
      ge_s = 1'b1;
    end else if (sign_a_s != sign_b_s) begin
      ge_s = ~sign_a_s;
    end else if (!sign_a_s) begin
      ge_s = (mag_a_s >= mag_b_s);
    end else begin
      ge_s = (mag_a_s <= mag_b_s);
    end
  end

  // Result register; ge/nan hold between operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      ge   <= 1'b0;
      nan  <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        ge  <= ge_s;
        nan <= nan_s;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_scheduler.sv
// Round-robin scheduler sharing one fp_ge_unit among NUM_REQ requesters,
// one operation in flight: grant, one-cycle start, wait for done, tagged response.
module fp_cmp_scheduler
  import fp_pkg::*;
#(
  parameter int precision     = 32,
  parameter int exp_size      = 8,
  parameter int mantissa_size = 23,
  parameter int NUM_REQ       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*precision-1:0]   op_a,
  input  logic [NUM_REQ*precision-1:0]   op_b,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_ge,
  output logic                           rsp_nan,
  output logic                           busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_r;
  logic [IW-1:0]        rr_ptr_r;
  logic [IW-1:0]        winner_r;
  logic [precision-1:0] a_r;
  logic [precision-1:0] b_r;
  logic [IW-1:0]        pick_s;
  logic [IW-1:0]        next_ptr_s;
  logic [precision-1:0] sel_a_s;
  logic [precision-1:0] sel_b_s;
  logic                 start_s;
  logic                 done_s;
  logic                 ge_s;
  logic                 nan_s;

  // First set request at or above p, wrapping; the lowest offset wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int            idx;
    w = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) begin
        w = IW'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Arbitration, operand select and the core start strobe.
  always_comb begin
    pick_s     = rr_pick(req, rr_ptr_r);
    next_ptr_s = (pick_s == IW'(NUM_REQ - 1)) ? IW'(0) : pick_s + IW'(1);
    sel_a_s    = precision'(op_a >> (pick_s * precision));
    sel_b_s    = precision'(op_b >> (pick_s * precision));
    start_s    = (state_r == EXEC);
  end

  // Scheduler FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      winner_r  <= '0;
      a_r       <= '0;
      b_r       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_ge    <= 1'b0;
      rsp_nan   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= '0;
          if (|req) begin
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            winner_r <= pick_s;
            rr_ptr_r <= next_ptr_s;
            gnt      <= onehot(pick_s);
            busy     <= 1'b1;
            state_r  <= EXEC;
          end else begin
            gnt <= '0;
          end
        end
        EXEC: begin
          gnt     <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (done_s) begin
            rsp_valid <= onehot(winner_r);
            rsp_ge    <= ge_s;
            rsp_nan   <= nan_s;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          rsp_valid <= '0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  fp_ge_unit #(
    .precision     (precision),
    .exp_size      (exp_size),
    .mantissa_size (mantissa_size)
  ) u_ge (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .a     (a_r),
    .b     (b_r),
    .done  (done_s),
    .ge    (ge_s),
    .nan   (nan_s)
  );

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// Directed and randomized bench for fp_cmp_scheduler against a real-valued compare
// model and an arithmetic round-robin model.
module tb_fp_cmp_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  a_v [4];
  logic [31:0]  b_v [4];
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic         rsp_ge;
  logic         rsp_nan;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  assign op_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign op_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

  always #5 clk = ~clk;

  fp_cmp_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ge    (rsp_ge),
    .rsp_nan   (rsp_nan),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Numeric value of a single-precision word; infinity maps beyond the finite range.
  function automatic real fval(input logic [31:0] x);
    int  e;
    int  m;
    real mag;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(m) * (2.0 ** (-149));
    else             mag = real'(m + 8388608) * (2.0 ** (e - 150));
    return x[31] ? -mag : mag;
  endfunction

  task automatic model_cmp(input logic [31:0] a, input logic [31:0] b, output logic ge, output logic nan);
    nan = ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) || ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0));
    ge  = !nan && (fval(a) >= fval(b));
  endtask

  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31], 8'hFF, r[22:0] | 23'h1};
      1: return {r[31], 31'h0};
      2: return {r[31], 8'hFF, 23'h0};
      3: return {r[31], 8'h00, r[22:0]};
      default: return r;
    endcase
  endfunction

  // One full operation from the IDLE cycle; req_exec/req_wait are req during EXEC/WAIT.
  task automatic run_op(input logic [3:0] pat, input logic [3:0] req_exec, input logic [3:0] req_wait, input string tag);
    int         w;
    logic       eg;
    logic       en;
    logic [3:0] exp_oh;
    req = pat;
    w = model_pick(pat);
    model_ptr = (w + 1) % 4;
    model_cmp(a_v[w], b_v[w], eg, en);
    exp_oh = 4'b0001 << w;
    @(posedge clk); #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_oh));
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    chk({tag, ".rv0"}, 32'(rsp_valid), 32'd0);
    req = req_exec;
    a_v[w] = $urandom;
    b_v[w] = $urandom;
    @(posedge clk); #1;
    chk({tag, ".gnt0"}, 32'(gnt), 32'd0);
    chk({tag, ".rv1"}, 32'(rsp_valid), 32'd0);
    req = req_wait;
    @(posedge clk); #1;
    chk({tag, ".rv"}, 32'(rsp_valid), 32'(exp_oh));
    chk({tag, ".ge"}, 32'(rsp_ge), 32'(eg));
    chk({tag, ".nan"}, 32'(rsp_nan), 32'(en));
    chk({tag, ".busy0"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      a_v[k] = 32'h0;
      b_v[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.rv", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: 1.0 >= 2.0 is false.
    a_v[0] = 32'h3F800000; b_v[0] = 32'h40000000;
    run_op(4'b0001, 4'b0000, 4'b0000, "t1");

    // Test 2: signed zeros, negatives and the swapped pair.
    a_v[1] = 32'h00000000; b_v[1] = 32'h80000000;
    run_op(4'b0010, 4'b0000, 4'b0000, "t2a");
    a_v[1] = 32'hBF800000; b_v[1] = 32'hC0000000;
    run_op(4'b0010, 4'b0000, 4'b0000, "t2b");
    a_v[1] = 32'hC0000000; b_v[1] = 32'hBF800000;
    run_op(4'b0010, 4'b0000, 4'b0000, "t2c");

    // Test 3: NaN then +inf against the largest finite value.
    a_v[2] = 32'h7FC00000; b_v[2] = 32'h3F800000;
    run_op(4'b0100, 4'b0000, 4'b0000, "t3a");
    a_v[2] = 32'h7F800000; b_v[2] = 32'h7F7FFFFF;
    run_op(4'b0100, 4'b0000, 4'b0000, "t3b");

    // Test 4: all requesters held; grants rotate every three cycles.
    for (int k = 0; k < 4; k++) begin
      a_v[k] = rand_fp();
      b_v[k] = rand_fp();
    end
    for (int n = 0; n < 6; n++) run_op(4'b1111, 4'b1111, 4'b1111, "t4");
    req = 4'b0000;
    @(posedge clk); #1;

    // Test 5: reset while waiting for the compare result.
    a_v[0] = 32'h40000000; b_v[0] = 32'h3F800000;
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t5.gnt", 32'(gnt), 32'(4'b0001 << model_pick(4'b0001)));
    req = 4'b0000;
    @(posedge clk); #1;
    chk("t5.busyw", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5.async_busy", 32'(busy), 32'd0);
    chk("t5.async_gnt", 32'(gnt), 32'd0);
    chk("t5.async_rv", 32'(rsp_valid), 32'd0);
    chk("t5.async_ge", 32'(rsp_ge), 32'd0);
    chk("t5.async_nan", 32'(rsp_nan), 32'd0);
    @(posedge clk); #1;
    chk("t5.hold_rv", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    model_ptr = 0;
    @(posedge clk); #1;
    chk("t5.norv", 32'(rsp_valid), 32'd0);
    a_v[2] = 32'h3F800000; b_v[2] = 32'h3F800000;
    run_op(4'b0100, 4'b0000, 4'b0000, "t5b");

    // Test 6: req[3] pulsed only while busy is never served.
    a_v[0] = rand_fp(); b_v[0] = rand_fp();
    a_v[2] = rand_fp(); b_v[2] = rand_fp();
    run_op(4'b0001, 4'b1100, 4'b0100, "t6a");
    run_op(4'b0100, 4'b0000, 4'b0000, "t6b");
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("t6.idle_gnt", 32'(gnt), 32'd0);
      chk("t6.idle_busy", 32'(busy), 32'd0);
    end

    // Randomized request patterns and operands.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        a_v[k] = rand_fp();
        case ($urandom_range(0, 3))
          0: b_v[k] = a_v[k];
          1: b_v[k] = a_v[k] ^ 32'h1;
          2: b_v[k] = a_v[k] ^ 32'h80000000;
          default: b_v[k] = rand_fp();
        endcase
      end
      run_op(4'($urandom_range(1, 15)), 4'b0000, 4'b0000, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
